// File: rtl/remote_link_pkg.sv
// Shared types and constants for the knight-side command link.
package remote_link_pkg;

  // UART engine phases (used by both the receiver and the transmitter).
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Command byte-assembly phase: which half of the 16-bit command is next.
  typedef enum logic {
    HIGH,
    LOW
  } asm_state_t;

  // Positive acknowledge byte returned to the host.
  localparam logic [7:0] POS_ACK = 8'hA5;

  // 50 MHz system clock / 19200 baud.
  localparam int DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_xcvr.sv
// Full-duplex UART: independent receive and transmit engines sharing one clock.
// Receive: 2-flop synchronizer, falling-edge start detect, centre sampling,
// rx_rdy pulse on a good stop bit, frm_err pulse on a bad one.
// Transmit: start, 8 data bits LSB first, stop; tx_done pulses as the stop bit ends.
// Handshake: trmt is a 1-cycle request that is accepted only when tx_busy is low;
// tx_busy rises the cycle after acceptance and falls together with the tx_done pulse.
module uart_xcvr
  import remote_link_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int BAUD_W   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx_busy
);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);

  // ---------------- receiver ----------------
  logic              rx_ff1;
  logic              rx_s;
  logic              rx_prev;
  uart_state_t       rx_state;
  logic [BAUD_W-1:0] rx_cnt;
  logic [3:0]        rx_bits;
  logic [7:0]        rx_shift;

  assign rx_data = rx_shift;

  // Synchronize RX and keep its previous value for falling-edge detection; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ff1  <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_s    <= rx_ff1;
      rx_prev <= rx_s;
    end
  end

  // Receive FSM: rx_bits counts samples taken (start=1, data 2..9, stop=10).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_rdy   <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rx_rdy  <= 1'b0;
      frm_err <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= START;
            rx_cnt   <= '0;
            rx_bits  <= '0;
          end
        end
        START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            // A line already back high at the start-bit centre was a glitch.
            if (rx_s) begin
              rx_state <= IDLE;
            end else begin
              rx_state <= DATA;
              rx_bits  <= 4'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bits  <= rx_bits + 4'd1;
            if (rx_bits == 4'd8) rx_state <= STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt   <= '0;
            rx_bits  <= rx_bits + 4'd1;
            rx_state <= IDLE;
            if (rx_s) rx_rdy  <= 1'b1;
            else      frm_err <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  uart_state_t       tx_state;
  logic [BAUD_W-1:0] tx_cnt;
  logic [3:0]        tx_bits;
  logic [7:0]        tx_shift;

  // Transmit FSM: TX is registered; tx_bits counts completed bit times (stop ends at 10).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
      TX       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        IDLE: begin
          if (trmt) begin
            tx_shift <= tx_data;
            TX       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt   <= '0;
            tx_bits  <= 4'd1;
            TX       <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[7:1]};
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt  <= '0;
            tx_bits <= tx_bits + 4'd1;
            if (tx_bits == 4'd8) begin
              TX       <= 1'b1;
              tx_state <= STOP;
            end else begin
              TX       <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt   <= '0;
            tx_bits  <= tx_bits + 4'd1;
            tx_done  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_state <= IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/remote_cmd_link.sv
// Knight-side command link: assembles two received bytes (high first) into a
// 16-bit command for cmd_proc and sends a response byte back on request.
// cmd_rdy is a level that stays high until clr_cmd_rdy or until the high byte
// of a newer command arrives; a completing low byte beats a same-cycle clear.
module remote_cmd_link
  import remote_link_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int BAUD_W   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err
);

  logic [7:0] rx_data;
  logic       rx_rdy;
  asm_state_t asm_state;

  uart_xcvr #(
    .BAUD_DIV(BAUD_DIV),
    .BAUD_W  (BAUD_W)
  ) u_xcvr (
    .clk    (clk),
    .rst    (rst),
    .RX     (RX),
    .TX     (TX),
    .rx_data(rx_data),
    .rx_rdy (rx_rdy),
    .frm_err(frm_err),
    .trmt   (send_resp),
    .tx_data(resp),
    .tx_done(resp_sent),
    .tx_busy(tx_busy)
  );

  // Byte-assembly FSM with the command register and cmd_rdy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_state <= HIGH;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
    end else begin
      if (rx_rdy) begin
        if (asm_state == HIGH) begin
          cmd[15:8] <= rx_data;
          cmd_rdy   <= 1'b0;
          asm_state <= LOW;
        end else begin
          cmd[7:0]  <= rx_data;
          cmd_rdy   <= 1'b1;
          asm_state <= HIGH;
        end
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
      // A corrupted byte leaves the pairing unknown; resynchronize on a high byte.
      if (frm_err) asm_state <= HIGH;
    end
  end

endmodule

// File: tb/tb_remote_cmd_link.sv
// Directed bench for remote_cmd_link at a short baud divisor.
module tb_remote_cmd_link;

  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        tx_busy;
  logic        frm_err;

  remote_cmd_link #(
    .BAUD_DIV(B),
    .BAUD_W  (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .send_resp  (send_resp),
    .resp_sent  (resp_sent),
    .tx_busy    (tx_busy),
    .frm_err    (frm_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;
  int frm_cnt = 0;
  int sent_cnt = 0;

  always @(negedge clk) begin
    if (frm_err)   frm_cnt++;
    if (resp_sent) sent_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(B);
    end
    RX = stop_bit;
    tick(B);
    RX = 1'b1;
    tick(4);
  endtask

  task automatic send_cmd(input logic [15:0] w);
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] word;     // command sent by the host
    logic [15:0] exp_mid;  // cmd after the high byte only
    logic        do_clr;   // acknowledge after completion
  } cmd_vec_t;

  cmd_vec_t vecs[5];

  logic [9:0] frame;
  logic       found;
  int         f0;

  initial begin
    vecs[0] = '{16'h6033, 16'h6000, 1'b1};
    vecs[1] = '{16'h2002, 16'h2033, 1'b0};
    vecs[2] = '{16'h4001, 16'h4002, 1'b1};
    vecs[3] = '{16'hFFFF, 16'hFF01, 1'b0};
    vecs[4] = '{16'h0000, 16'h00FF, 1'b1};

    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
    tick(3);
    check("rst_TX", TX, 1);
    check("rst_cmd", cmd, 0);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_resp_sent", resp_sent, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_frm_err", frm_err, 0);
    rst = 1'b0;
    tick(3);

    // Command table: assembly, overwrite, hold and acknowledge.
    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].word[15:8], 1'b1);
      check("mid_cmd_rdy", cmd_rdy, 0);
      check("mid_cmd", cmd, vecs[i].exp_mid);
      send_byte(vecs[i].word[7:0], 1'b1);
      check("cmd", cmd, vecs[i].word);
      check("cmd_rdy", cmd_rdy, 1);
      if (vecs[i].do_clr) begin
        tick(20);
        check("cmd_rdy_hold", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("cmd_rdy_clr", cmd_rdy, 0);
        check("cmd_after_clr", cmd, vecs[i].word);
      end
    end

    // Response frame 0xA5 with an ignored mid-frame request.
    frame = {1'b1, 8'hA5, 1'b0};
    resp = 8'hA5;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    check("tx_busy_rise", tx_busy, 1);
    check("tx_start", TX, 0);
    for (int c = 1; c <= 10 * B; c++) begin
      tick(1);
      if (send_resp) send_resp = 1'b0;
      if (c % B == B / 2) check("tx_bit", TX, frame[c / B]);
      if (c == 3 * B) begin
        resp = 8'h00;
        send_resp = 1'b1;
      end
      if (c == 10 * B - 1) begin
        check("resp_sent_early", resp_sent, 0);
        check("tx_busy_hold", tx_busy, 1);
      end
    end
    check("resp_sent_pulse", resp_sent, 1);
    check("tx_busy_drop", tx_busy, 0);
    // Request in the resp_sent cycle is accepted.
    resp = 8'h3C;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    check("b2b_busy", tx_busy, 1);
    check("b2b_start", TX, 0);
    check("resp_sent_once", sent_cnt, 1);
    found = 1'b0;
    for (int k = 0; k < 11 * B && !found; k++) begin
      tick(1);
      if (resp_sent) found = 1'b1;
    end
    check("b2b_done", found, 1);
    tick(3 * B);
    check("no_queued_frame", tx_busy, 0);
    check("resp_sent_count", sent_cnt, 2);

    // Short glitch on idle RX, then a framing error in the LOW phase.
    f0 = frm_cnt;
    RX = 1'b0;
    tick(5);
    RX = 1'b1;
    tick(3 * B);
    check("glitch_frm", frm_cnt, f0);
    check("glitch_cmd", cmd, 16'h0000);
    send_byte(8'h12, 1'b1);
    check("hi_after_glitch", cmd, 16'h1200);
    send_byte(8'h60, 1'b0);
    check("frm_err_once", frm_cnt, f0 + 1);
    check("frm_discard", cmd, 16'h1200);
    send_cmd(16'h2002);
    check("cmd_after_frm", cmd, 16'h2002);
    check("rdy_after_frm", cmd_rdy, 1);

    // Clear in the same cycle as low-byte completion: set wins, 1-clk latency.
    send_byte(8'hAB, 1'b1);
    check("overwrite_drop", cmd_rdy, 0);
    fork
      send_byte(8'hCD, 1'b1);
      begin
        found = 1'b0;
        for (int k = 0; k < 12 * B && !found; k++) begin
          @(negedge clk);
          if (dut.u_xcvr.rx_rdy) begin
            found = 1'b1;
            check("rdy_before_set", cmd_rdy, 0);
            clr_cmd_rdy = 1'b1;
            @(posedge clk);
            #1;
            clr_cmd_rdy = 1'b0;
            check("set_wins", cmd_rdy, 1);
          end
        end
        check("rx_rdy_seen", found, 1);
      end
    join
    check("cmd_abcd", cmd, 16'hABCD);

    // Reset in the middle of a received byte and a transmitted frame.
    resp = 8'h55;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    RX = 1'b0;
    tick(B);
    RX = 1'b1;
    tick(B);
    RX = 1'b0;
    tick(3);
    rst = 1'b1;
    RX = 1'b1;
    tick(2);
    check("mid_rst_TX", TX, 1);
    check("mid_rst_cmd", cmd, 0);
    check("mid_rst_cmd_rdy", cmd_rdy, 0);
    check("mid_rst_tx_busy", tx_busy, 0);
    check("mid_rst_resp_sent", resp_sent, 0);
    check("mid_rst_frm_err", frm_err, 0);
    rst = 1'b0;
    tick(3);
    send_cmd(16'h5BEE);
    check("cmd_after_rst", cmd, 16'h5BEE);
    check("rdy_after_rst", cmd_rdy, 1);
    check("tx_aborted", sent_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
